// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit: opcodes, jump-condition codes,
// FSM state encoding and the packed control word driven to the datapath.
package cpu_pkg;

  // Instruction opcode field [15:12]; every encoding is named so decode is total.
  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_ALU_RR = 4'h1,
    OP_ALU_RI = 4'h2,
    OP_LDI    = 4'h3,
    OP_LOAD   = 4'h4,
    OP_STORE  = 4'h5,
    OP_JMP    = 4'h6,
    OP_HALT   = 4'h7,
    OP_CALL   = 4'h8,
    OP_PUSH   = 4'h9,
    OP_RTI    = 4'hA,
    OP_POP    = 4'hB,
    OP_RSV_C  = 4'hC,
    OP_RSV_D  = 4'hD,
    OP_RSV_E  = 4'hE,
    OP_RSV_F  = 4'hF
  } opcode_e;

  // Jump condition codes carried in the func field; 5..F never jump.
  localparam logic [3:0] JC_ALWAYS = 4'h0;
  localparam logic [3:0] JC_Z      = 4'h1;
  localparam logic [3:0] JC_NZ     = 4'h2;
  localparam logic [3:0] JC_N      = 4'h3;
  localparam logic [3:0] JC_NN     = 4'h4;

  typedef enum logic [2:0] {
    ST_FETCH0    = 3'd0,
    ST_FETCH1    = 3'd1,
    ST_EXEC      = 3'd2,
    ST_LOAD_ADDR = 3'd3,
    ST_LOAD_WB   = 3'd4,
    ST_IRQ       = 3'd5,
    ST_HALT      = 3'd6
  } state_e;

  // Control word; mem_write_next_pc is not listed because it is tied low.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic fetch_instruction;
    logic alu_override_imm8;
    logic alu_override_imm4;
    logic alu_set_flags;
    logic set_pc;
    logic pc_from_register;
    logic pc_from_irq;
    logic mem_write;
    logic mem_write_is_stack;
    logic mem_write_this_pc;
    logic set_sp;
    logic increase_sp;
    logic reset_irq;
    logic halted;
  } ctrl_t;

  // Opcode field of an instruction word.
  function automatic opcode_e opcode_of(input logic [3:0] op_field);
    return opcode_e'(op_field);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle. The control unit is the master: it
// consumes the latched instruction, flags and irq, and drives the strobes.
interface control_unit_if;
  logic [15:0] current_instruction;
  logic        Z_in;
  logic        N_in;
  logic        irq;

  logic        reg_write;
  logic        mem_to_reg;
  logic        fetch_instruction;
  logic        alu_override_imm8;
  logic        alu_override_imm4;
  logic        alu_set_flags;
  logic        set_pc;
  logic        pc_from_register;
  logic        pc_from_irq;
  logic        mem_write;
  logic        mem_write_is_stack;
  logic        mem_write_next_pc;
  logic        mem_write_this_pc;
  logic        set_sp;
  logic        increase_sp;
  logic        reset_irq;
  logic        halted;

  modport master (
    input  current_instruction, Z_in, N_in, irq,
    output reg_write, mem_to_reg, fetch_instruction, alu_override_imm8,
           alu_override_imm4, alu_set_flags, set_pc, pc_from_register,
           pc_from_irq, mem_write, mem_write_is_stack, mem_write_next_pc,
           mem_write_this_pc, set_sp, increase_sp, reset_irq, halted
  );

  modport slave (
    output current_instruction, Z_in, N_in, irq,
    input  reg_write, mem_to_reg, fetch_instruction, alu_override_imm8,
           alu_override_imm4, alu_set_flags, set_pc, pc_from_register,
           pc_from_irq, mem_write, mem_write_is_stack, mem_write_next_pc,
           mem_write_this_pc, set_sp, increase_sp, reset_irq, halted
  );
endinterface

// File: rtl/jump_cond.sv
// Evaluates the conditional-jump predicate from the func field and SR flags.
module jump_cond
  import cpu_pkg::*;
(
  input  logic [3:0] func_i,
  input  logic       z_i,
  input  logic       n_i,
  output logic       taken_o
);

  // Condition decode; unassigned codes never jump.
  always_comb begin
    taken_o = 1'b0;
    case (func_i)
      JC_ALWAYS: taken_o = 1'b1;
      JC_Z:      taken_o = z_i;
      JC_NZ:     taken_o = ~z_i;
      JC_N:      taken_o = n_i;
      JC_NN:     taken_o = ~n_i;
      default:   taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: two-cycle fetch, single EXEC cycle, extra
// memory phases for LOAD/POP, a one-cycle interrupt entry and a HALT sink.
module control_unit
  import cpu_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  control_unit_if.master cu_if
);

  state_e  state_q, state_d;
  logic    in_isr_q, in_isr_d;
  ctrl_t   ctrl;
  logic    jmp_taken;
  opcode_e opcode;

  assign opcode = opcode_of(cu_if.current_instruction[15:12]);

  jump_cond u_jump_cond (
    .func_i  (cu_if.current_instruction[3:0]),
    .z_i     (cu_if.Z_in),
    .n_i     (cu_if.N_in),
    .taken_o (jmp_taken)
  );

  // State and ISR flag registers; reset abandons any instruction in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_FETCH0;
      in_isr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_isr_q <= in_isr_d;
    end
  end

  // Next-state and control decode; all strobes forced low while in reset.
  always_comb begin
    state_d  = state_q;
    in_isr_d = in_isr_q;
    ctrl     = '0;

    case (state_q)
      ST_FETCH0: begin
        // Interrupt entry is taken only at an instruction boundary and
        // not nested; the fetch is skipped entirely in that case.
        if (cu_if.irq && !in_isr_q && reset) begin
          state_d = ST_IRQ;
        end else begin
          ctrl.fetch_instruction = 1'b1;
          state_d                = ST_FETCH1;
        end
      end

      ST_FETCH1: begin
        // Read data valid this cycle: latch instruction and step PC.
        ctrl.fetch_instruction = 1'b1;
        ctrl.set_pc            = 1'b1;
        state_d                = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = ST_FETCH0;
        case (opcode)
          OP_ALU_RR: begin
            ctrl.reg_write     = 1'b1;
            ctrl.alu_set_flags = 1'b1;
          end
          OP_ALU_RI: begin
            ctrl.reg_write         = 1'b1;
            ctrl.alu_set_flags     = 1'b1;
            ctrl.alu_override_imm4 = 1'b1;
          end
          OP_LDI: begin
            ctrl.reg_write         = 1'b1;
            ctrl.alu_override_imm8 = 1'b1;
          end
          OP_LOAD: begin
            // Address presented this cycle; data written back next cycle.
            state_d = ST_LOAD_WB;
          end
          OP_STORE: begin
            ctrl.mem_write = 1'b1;
          end
          OP_JMP: begin
            ctrl.set_pc           = jmp_taken;
            ctrl.pc_from_register = jmp_taken;
          end
          OP_HALT: begin
            state_d = ST_HALT;
          end
          OP_CALL: begin
            ctrl.mem_write          = 1'b1;
            ctrl.mem_write_is_stack = 1'b1;
            ctrl.mem_write_this_pc  = 1'b1;
            ctrl.set_sp             = 1'b1;
            ctrl.set_pc             = 1'b1;
            ctrl.pc_from_register   = 1'b1;
          end
          OP_PUSH: begin
            ctrl.mem_write          = 1'b1;
            ctrl.mem_write_is_stack = 1'b1;
            ctrl.set_sp             = 1'b1;
          end
          OP_RTI: begin
            ctrl.set_pc           = 1'b1;
            ctrl.pc_from_register = 1'b1;
            in_isr_d              = 1'b0;
          end
          OP_POP: begin
            // SP is pre-incremented, then the read goes through LOAD_ADDR
            // with r2 encoded as SP (r13).
            ctrl.set_sp      = 1'b1;
            ctrl.increase_sp = 1'b1;
            state_d          = ST_LOAD_ADDR;
          end
          default: ;  // NOP and reserved opcodes
        endcase
      end

      ST_LOAD_ADDR: begin
        state_d = ST_LOAD_WB;
      end

      ST_LOAD_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = ST_FETCH0;
      end

      ST_IRQ: begin
        // Push current PC and jump through the vector held in r12.
        ctrl.mem_write          = 1'b1;
        ctrl.mem_write_is_stack = 1'b1;
        ctrl.mem_write_this_pc  = 1'b1;
        ctrl.set_sp             = 1'b1;
        ctrl.pc_from_irq        = 1'b1;
        ctrl.pc_from_register   = 1'b1;
        ctrl.set_pc             = 1'b1;
        ctrl.reset_irq          = 1'b1;
        in_isr_d                = 1'b1;
        state_d                 = ST_FETCH0;
      end

      ST_HALT: begin
        ctrl.halted = 1'b1;
      end

      default: begin
        state_d = ST_FETCH0;
      end
    endcase

    if (!reset) begin
      ctrl = '0;
    end
  end

  assign cu_if.reg_write          = ctrl.reg_write;
  assign cu_if.mem_to_reg         = ctrl.mem_to_reg;
  assign cu_if.fetch_instruction  = ctrl.fetch_instruction;
  assign cu_if.alu_override_imm8  = ctrl.alu_override_imm8;
  assign cu_if.alu_override_imm4  = ctrl.alu_override_imm4;
  assign cu_if.alu_set_flags      = ctrl.alu_set_flags;
  assign cu_if.set_pc             = ctrl.set_pc;
  assign cu_if.pc_from_register   = ctrl.pc_from_register;
  assign cu_if.pc_from_irq        = ctrl.pc_from_irq;
  assign cu_if.mem_write          = ctrl.mem_write;
  assign cu_if.mem_write_is_stack = ctrl.mem_write_is_stack;
  assign cu_if.mem_write_next_pc  = 1'b0;
  assign cu_if.mem_write_this_pc  = ctrl.mem_write_this_pc;
  assign cu_if.set_sp             = ctrl.set_sp;
  assign cu_if.increase_sp        = ctrl.increase_sp;
  assign cu_if.reset_irq          = ctrl.reset_irq;
  assign cu_if.halted             = ctrl.halted;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: each step sets inputs on the falling edge,
// then compares the full control vector against a hand-computed value.
module tb_control_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  control_unit_if bus_if ();

  control_unit dut (
    .clock (clk),
    .reset (rst_n),
    .cu_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bit masks
  localparam logic [16:0] RW   = 17'h00001;  // reg_write
  localparam logic [16:0] M2R  = 17'h00002;  // mem_to_reg
  localparam logic [16:0] FI   = 17'h00004;  // fetch_instruction
  localparam logic [16:0] IMM8 = 17'h00008;
  localparam logic [16:0] IMM4 = 17'h00010;
  localparam logic [16:0] SF   = 17'h00020;  // alu_set_flags
  localparam logic [16:0] SPC  = 17'h00040;  // set_pc
  localparam logic [16:0] PFR  = 17'h00080;  // pc_from_register
  localparam logic [16:0] PFI  = 17'h00100;  // pc_from_irq
  localparam logic [16:0] MW   = 17'h00200;  // mem_write
  localparam logic [16:0] MWS  = 17'h00400;  // mem_write_is_stack
  localparam logic [16:0] MWT  = 17'h01000;  // mem_write_this_pc
  localparam logic [16:0] SSP  = 17'h02000;  // set_sp
  localparam logic [16:0] ISP  = 17'h04000;  // increase_sp
  localparam logic [16:0] RIRQ = 17'h08000;  // reset_irq
  localparam logic [16:0] HLT  = 17'h10000;  // halted

  localparam logic [16:0] NONE     = 17'h00000;
  localparam logic [16:0] CALL_EXP = MW | MWS | MWT | SSP | SPC | PFR;
  localparam logic [16:0] IRQ_EXP  = MW | MWS | MWT | SSP | PFI | PFR | SPC | RIRQ;

  logic [16:0] outs;
  assign outs = {bus_if.halted, bus_if.reset_irq, bus_if.increase_sp,
                 bus_if.set_sp, bus_if.mem_write_this_pc,
                 bus_if.mem_write_next_pc, bus_if.mem_write_is_stack,
                 bus_if.mem_write, bus_if.pc_from_irq,
                 bus_if.pc_from_register, bus_if.set_pc,
                 bus_if.alu_set_flags, bus_if.alu_override_imm4,
                 bus_if.alu_override_imm8, bus_if.fetch_instruction,
                 bus_if.mem_to_reg, bus_if.reg_write};

  // One clock step: settle, compare, advance to the next falling edge.
  task automatic cyc(input string tag, input logic [16:0] exp);
    #1;
    total++;
    assert (outs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, outs, exp);
    end
    @(negedge clk);
  endtask

  // FETCH0 then FETCH1 for a fresh instruction.
  task automatic fetch(input string tag, input logic [15:0] instr);
    cyc({tag, "_f0"}, FI);
    bus_if.current_instruction = instr;
    cyc({tag, "_f1"}, FI | SPC);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus_if.current_instruction = 16'h0000;
    bus_if.Z_in = 1'b0;
    bus_if.N_in = 1'b0;
    bus_if.irq  = 1'b0;
    @(negedge clk);

    // Reset: outputs low even with irq asserted
    cyc("rst0", NONE);
    bus_if.irq = 1'b1;
    cyc("rst1_irq", NONE);
    bus_if.irq = 1'b0;
    rst_n = 1'b1;

    // ALU reg-reg
    fetch("alu", 16'h1231);
    cyc("alu_exec", RW | SF);
    // ALU reg-imm4
    fetch("alui", 16'h2315);
    cyc("alui_exec", RW | SF | IMM4);
    // LDI
    fetch("ldi", 16'h37F0);
    cyc("ldi_exec", RW | IMM8);
    // LOAD: 4 cycles
    fetch("load", 16'h4350);
    cyc("load_exec", NONE);
    cyc("load_wb", RW | M2R);
    // STORE
    fetch("store", 16'h5350);
    cyc("store_exec", MW);
    // JMP on Z, not taken then taken
    fetch("jz0", 16'h6501);
    cyc("jz0_exec", NONE);
    bus_if.Z_in = 1'b1;
    fetch("jz1", 16'h6501);
    cyc("jz1_exec", SPC | PFR);
    // JMP on !N with N=1: not taken; JMP never (func F) with flags set
    bus_if.N_in = 1'b1;
    fetch("jnn", 16'h6504);
    cyc("jnn_exec", NONE);
    fetch("jnever", 16'h650F);
    cyc("jnever_exec", NONE);
    bus_if.Z_in = 1'b0;
    fetch("jn", 16'h6503);
    cyc("jn_exec", SPC | PFR);
    bus_if.N_in = 1'b0;
    // CALL, PUSH
    fetch("call", 16'h8500);
    cyc("call_exec", CALL_EXP);
    fetch("push", 16'h9500);
    cyc("push_exec", MW | MWS | SSP);
    // POP: 5 cycles
    fetch("pop", 16'hB2D0);
    cyc("pop_exec", SSP | ISP);
    cyc("pop_addr", NONE);
    cyc("pop_wb", RW | M2R);
    // Reserved opcode acts as NOP
    fetch("rsv", 16'hE123);
    cyc("rsv_exec", NONE);

    // Reset mid-instruction (during LOAD EXEC) abandons it
    fetch("ldrst", 16'h4350);
    rst_n = 1'b0;
    cyc("ldrst_exec_rst", NONE);
    rst_n = 1'b1;

    // Interrupt entry, then irq held: no nesting until RTI
    bus_if.irq = 1'b1;
    cyc("irq_f0", NONE);
    cyc("irq_cycle", IRQ_EXP);
    fetch("isr", 16'h1231);
    cyc("isr_exec", RW | SF);
    fetch("rti", 16'hA000);
    cyc("rti_exec", SPC | PFR);
    cyc("irq2_f0", NONE);
    cyc("irq2_cycle", IRQ_EXP);
    bus_if.irq = 1'b0;

    // HALT: terminal, ignores irq pulses
    fetch("halt", 16'h7000);
    cyc("halt_exec", NONE);
    cyc("halt0", HLT);
    bus_if.irq = 1'b1;
    cyc("halt_irq", HLT);
    bus_if.irq = 1'b0;
    cyc("halt1", HLT);
    rst_n = 1'b0;
    cyc("halt_rst", NONE);
    rst_n = 1'b1;
    cyc("post_rst_f0", FI);
    bus_if.current_instruction = 16'h0000;
    cyc("post_rst_f1", FI | SPC);
    cyc("post_rst_nop", NONE);
    // in_isr cleared by reset: irq is taken again
    bus_if.irq = 1'b1;
    cyc("post_rst_irq_f0", NONE);
    cyc("post_rst_irq", IRQ_EXP);
    bus_if.irq = 1'b0;
    cyc("post_rst_after_irq", FI);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows:
  clock  in  1  system clock, all state changes on rising edge
  reset  in  1  synchronous active-low reset
REQ-002 The block SHALL have the following inputs from the datapath:
  current_instruction  in  16  latched instruction: opcode [15:12], r1 [11:8], r2 [7:4], func [3:0]
  Z_in  in  1  SR zero flag
  N_in  in  1  SR negative flag
  irq  in  1  OR of peripheral interrupt requests
REQ-003 The block SHALL drive the following control outputs to the datapath:
  reg_write  out  1  write r1
  mem_to_reg  out  1  r1 write data from memory
  fetch_instruction  out  1  memory read address = PC, latch instruction
  alu_override_imm8  out  1  ALU result = sign-extended imm8
  alu_override_imm4  out  1  ALU b input = zero-extended imm4
  alu_set_flags  out  1  update SR flags
  set_pc  out  1  load PC with next PC
  pc_from_register  out  1  next PC = register read port 1
  pc_from_irq  out  1  register read port 1 = r12 (vector)
  mem_write  out  1  memory write strobe
  mem_write_is_stack  out  1  write address = SP
  mem_write_next_pc  out  1  write data = next PC (reserved, always 0)
  mem_write_this_pc  out  1  write data = current PC
  set_sp  out  1  update SP
  increase_sp  out  1  SP+1 (else SP-1)
  reset_irq  out  1  acknowledge/clear peripheral irq
  halted  out  1  core in HALT state

Function
REQ-004 The block SHALL be a Moore/Mealy FSM with states FETCH0, FETCH1, EXEC, LOAD_ADDR, LOAD_WB, IRQ and HALT, plus an in_isr flag; outputs are combinational from state, opcode, func and flags.
REQ-005 Memory read latency SHALL be one cycle: FETCH0 and FETCH1 both assert fetch_instruction; FETCH1 also asserts set_pc (PC+1); FETCH1 -> EXEC.
REQ-006 In FETCH0, if irq=1, in_isr=0 and reset=1, the block SHALL go to IRQ instead of FETCH1 and assert no outputs.
REQ-007 EXEC by opcode: 0x0 NOP; 0x1 ALU reg-reg (reg_write, alu_set_flags); 0x2 ALU reg-imm4 (plus alu_override_imm4); 0x3 LDI (reg_write, alu_override_imm8, no flag update); 0x4 LOAD (address phase, -> LOAD_WB); 0x5 STORE (mem_write).
REQ-008 EXEC, opcode 0x6 JMP: set_pc and pc_from_register iff the condition in func holds: 0 always, 1 Z, 2 !Z, 3 N, 4 !N, 5-F never; a not-taken jump asserts nothing.
REQ-009 EXEC, opcode 0x7 HALT: the next state SHALL be HALT, which is terminal until reset; HALT asserts halted=1 only and ignores irq.
REQ-010 EXEC, opcode 0x8 CALL SHALL be a single cycle asserting mem_write, mem_write_is_stack, mem_write_this_pc, set_sp (decrement), set_pc and pc_from_register.
REQ-011 EXEC, opcode 0x9 PUSH: mem_write, mem_write_is_stack, set_sp (decrement).
REQ-012 EXEC, opcode 0xB POP: set_sp with increase_sp, then LOAD_ADDR (no outputs, address = r2, encoded as r13), then LOAD_WB.
REQ-013 EXEC, opcode 0xA RTI: set_pc, pc_from_register, and clear in_isr.
REQ-014 Opcodes 0xC-0xF SHALL execute as NOP.
REQ-015 LOAD_WB SHALL assert reg_write and mem_to_reg, then go to FETCH0.
REQ-016 All other EXEC cases SHALL return to FETCH0. Cycle counts: 3 for ALU/jump/store/call, 4 for LOAD, 5 for POP.
REQ-017 IRQ SHALL be a single cycle asserting mem_write, mem_write_is_stack, mem_write_this_pc, set_sp (decrement), pc_from_irq, pc_from_register, set_pc and reset_irq; it sets in_isr and goes to FETCH0.
REQ-018 mem_write_next_pc SHALL be 0 in every state.

Reset
REQ-019 While reset=0 at a rising edge, the block SHALL set state to FETCH0 and in_isr to 0; reset mid-instruction SHALL abandon that instruction with no further outputs.
REQ-020 All outputs SHALL be 0 while reset=0, regardless of state.

Structure
REQ-021 The opcode values, jump-condition codes and state enum SHALL live in the shared package cpu_pkg.
REQ-022 One sub-module, jump_cond (func, Z_in, N_in -> taken), is natural; everything else is flat.

Verification
REQ-023 ALU: instruction 0x1231, flags clear -> reg_write=alu_set_flags=1 in the 3rd cycle only, back in FETCH0 in the 4th cycle.
REQ-024 LOAD: 0x4350 -> EXEC has no write; LOAD_WB asserts reg_write and mem_to_reg; sequence is 4 cycles.
REQ-025 JMP: 0x6501 with Z_in=0 -> no set_pc in EXEC; with Z_in=1 -> set_pc and pc_from_register both 1.
REQ-026 IRQ: irq=1 in FETCH0 -> IRQ cycle asserts all of REQ-017 plus reset_irq=1; irq held high -> no second IRQ until 0xA (RTI) executes.
REQ-027 POP: 0xB2D0 -> EXEC has set_sp=increase_sp=1, then LOAD_ADDR, then LOAD_WB with reg_write=mem_to_reg=1.
REQ-028 HALT/reset: 0x7000 -> halted=1 persists with irq pulsed; reset=0 for one cycle -> FETCH0 with all outputs 0.
